// File: rtl/merge_4.sv
// Four-input round-robin merge onto one registered output channel.
// Each output word carries the 2-bit index of the input it came from.
module merge_4 #(
    parameter int unsigned WIDTH = 11
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         in_valid,
    input  logic [4*WIDTH-1:0] in_data,
    output logic [3:0]         in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [1:0]         out_src,
    input  logic               out_ready
);

    logic [1:0]       rr_ptr;
    logic             can_accept;
    logic             gnt_any;
    logic             gnt_found;
    logic [1:0]       gnt_idx;
    logic [1:0]       cand;
    logic [WIDTH-1:0] words [4];

    for (genvar i = 0; i < 4; i++) begin : g_unpack
        assign words[i] = in_data[i*WIDTH +: WIDTH];
    end

    // Gating with rst_n makes in_ready fall as soon as reset asserts.
    assign can_accept = rst_n & (~out_valid | out_ready);

    // Search starts one past the last winner and wraps modulo 4.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = rr_ptr;
        cand      = rr_ptr;
        for (int k = 0; k < 4; k++) begin
            cand = rr_ptr + 2'(k + 1);
            if (!gnt_found && in_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
        gnt_any = gnt_found & can_accept;
    end

    assign in_ready = gnt_any ? (4'b0001 << gnt_idx) : 4'b0000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 2'd0;
            rr_ptr    <= 2'd0;
        end else if (gnt_any) begin
            out_valid <= 1'b1;
            out_data  <= words[gnt_idx];
            out_src   <= gnt_idx;
            rr_ptr    <= gnt_idx;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_merge_4.sv
// Randomised and directed checks of merge_4 against a transaction-level model:
// per-source send queues, per-source scoreboards and a round-robin grant predictor.
module tb_merge_4;

    localparam int W = 11;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [3:0]     in_valid;
    logic [4*W-1:0] in_data;
    logic [3:0]     in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [1:0]     out_src;
    logic           out_ready;

    merge_4 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Pending words per source, words accepted but not yet delivered per source.
    logic [W-1:0] src_q [4][$];
    logic [W-1:0] sb    [4][$];
    int           waitc [4];

    // Model of the output register and pointer.
    logic         m_valid;
    logic [W-1:0] m_data;
    int           m_src;
    int           m_ptr;
    logic [3:0]   obs_rdy;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // First requesting input after ptr, searching ptr+1, ptr+2, ... modulo 4.
    function automatic logic [3:0] ref_grant(input logic [3:0] v, input int ptr);
        for (int k = 1; k <= 4; k++) begin
            int j;
            j = (ptr + k) % 4;
            if (v[j]) return 4'(1 << j);
        end
        return 4'b0000;
    endfunction

    task automatic model_clear();
        m_valid = 1'b0;
        m_data  = '0;
        m_src   = 0;
        m_ptr   = 0;
        for (int i = 0; i < 4; i++) begin
            sb[i].delete();
            waitc[i] = 0;
        end
    endtask

    // One clock cycle: entered and left just after a falling edge.
    task automatic tick();
        logic [3:0] erdy;
        int         g;
        for (int i = 0; i < 4; i++) begin
            in_valid[i] = (src_q[i].size() != 0);
            in_data[i*W +: W] = in_valid[i] ? src_q[i][0] : W'($urandom);
        end
        #1;
        erdy = (!m_valid || out_ready) ? ref_grant(in_valid, m_ptr) : 4'b0000;
        obs_rdy = in_ready;
        chk("in_ready", 32'(in_ready), 32'(erdy));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_data", 32'(out_data), 32'(m_data));
        chk("out_src", 32'(out_src), 32'(m_src));
        if (out_valid && out_ready) begin
            chk("sb_nonempty", 32'(sb[out_src].size() != 0), 1);
            if (sb[out_src].size() != 0) chk("sb_order", 32'(out_data), 32'(sb[out_src].pop_front()));
        end
        g = -1;
        for (int i = 0; i < 4; i++) begin
            if (in_ready[i] && in_valid[i]) begin
                g = i;
                sb[i].push_back(src_q[i].pop_front());
            end
        end
        if (g >= 0) begin
            for (int i = 0; i < 4; i++) begin
                if (i != g && in_valid[i]) begin
                    waitc[i]++;
                    chk("max_wait", 32'(waitc[i] <= 3), 1);
                end
            end
            waitc[g] = 0;
        end
        @(posedge clk);
        if (erdy != 4'b0000) begin
            for (int i = 0; i < 4; i++) begin
                if (erdy[i]) begin
                    m_valid = 1'b1;
                    m_src   = i;
                    m_data  = in_data[i*W +: W];
                    m_ptr   = i;
                end
            end
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    // Asynchronous reset asserted mid-cycle; optionally wiggle inputs while held.
    task automatic apply_reset(input bit toggle);
        #3;
        rst_n = 1'b0;
        model_clear();
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_src", 32'(out_src), 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (toggle) begin
                in_valid  = 4'($urandom);
                in_data   = {$urandom, $urandom};
                out_ready = 1'($urandom);
            end
            #1;
            chk("rst_hold_valid", 32'(out_valid), 0);
            chk("rst_hold_ready", 32'(in_ready), 0);
            chk("rst_hold_src", 32'(out_src), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain(input string tag);
        int n;
        out_ready = 1'b1;
        n = 0;
        while (n < 60 && (m_valid || src_q[0].size() + src_q[1].size()
                          + src_q[2].size() + src_q[3].size() != 0)) begin
            tick();
            n++;
        end
        chk({tag, "_drained"}, 32'(n < 60), 1);
        for (int i = 0; i < 4; i++) chk({tag, "_sb_empty"}, 32'(sb[i].size()), 0);
    endtask

    int seq_t3 [6] = '{1, 2, 3, 0, 1, 2};
    logic [W-1:0] held_d;

    initial begin
        rst_n     = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;
        model_clear();
        @(negedge clk);

        // T1: reset with inputs toggling.
        apply_reset(1'b1);
        in_valid = '0;

        // T2: single source on input 3.
        out_ready = 1'b1;
        src_q[2].push_back(W'('h155));
        src_q[2].push_back(W'('h2AA));
        tick();
        chk("t2_rdy0", 32'(obs_rdy), 32'(4'b0100));
        chk("t2_d0", 32'(out_data), 'h155);
        chk("t2_s0", 32'(out_src), 2);
        tick();
        chk("t2_rdy1", 32'(obs_rdy), 32'(4'b0100));
        chk("t2_d1", 32'(out_data), 'h2AA);
        chk("t2_s1", 32'(out_src), 2);
        drain("t2");

        // T3: all four valid, pointer freshly reset.
        apply_reset(1'b0);
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 4; i++) if (src_q[i].size() == 0) src_q[i].push_back(W'('h100 + i));
            tick();
            chk("t3_src", 32'(out_src), 32'(seq_t3[k]));
        end

        // T5: reset mid-stream while the output register is full.
        for (int i = 0; i < 4; i++) if (src_q[i].size() == 0) src_q[i].push_back(W'('h100 + i));
        chk("t5_pre_valid", 32'(out_valid), 1);
        apply_reset(1'b0);
        out_ready = 1'b1;
        tick();
        chk("t5_rdy", 32'(obs_rdy), 32'(4'b0010));
        chk("t5_src", 32'(out_src), 1);
        drain("t5");

        // T4: backpressure with inputs 1 and 3 pending.
        apply_reset(1'b0);
        out_ready = 1'b0;
        src_q[0].push_back(W'('h0AB));
        src_q[2].push_back(W'('h3CD));
        tick();
        held_d = out_data;
        chk("t4_first", 32'(held_d), 'h3CD);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t4_rdy", 32'(obs_rdy), 0);
            chk("t4_hold_d", 32'(out_data), 32'(held_d));
            chk("t4_hold_s", 32'(out_src), 2);
        end
        drain("t4");

        // T6: random traffic and backpressure.
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < 4; i++)
                if (src_q[i].size() == 0 && ($urandom % 3) != 0) src_q[i].push_back(W'($urandom));
            out_ready = (($urandom % 4) != 0);
            tick();
        end
        drain("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
